// File: rtl/wren_sweep_decoder_pkg.sv
// Shared definitions for the register-file write-enable decoder with clear sweep.
package wren_sweep_decoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/wren_sweep_decoder_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable; all-zero when disabled.
module wren_sweep_decoder_onehot_dec #(
  parameter int unsigned SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] dec
);

  localparam int unsigned NUM_OUT = 2**SEL_W;

  always_comb begin
    dec = '0;
    if (en) begin
      dec = NUM_OUT'(1) << sel;
    end
  end

endmodule

// File: rtl/wren_sweep_decoder.sv
// Registered write-enable decoder for the register file, with a one-per-cycle clear sweep.
module wren_sweep_decoder
  import wren_sweep_decoder_pkg::*;
#(
  parameter int unsigned SEL_W        = 5,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  input  logic                  clear_req,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int unsigned    NUM_OUT = 2**SEL_W;
  localparam logic [SEL_W-1:0] FIRST = ZERO_PROTECT ? SEL_W'(1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_OUT - 1);

  state_t             state;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   idx_nxt_c;
  logic [SEL_W-1:0]   dec_sel_c;
  logic               dec_en_c;
  logic [NUM_OUT-1:0] dec_c;

  assign idx_nxt_c = idx + SEL_W'(1);

  // Single decoder shared between normal writes and the sweep walk.
  always_comb begin
    dec_sel_c = sel;
    dec_en_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          dec_sel_c = FIRST;
          dec_en_c  = 1'b1;
        end else if (en) begin
          dec_sel_c = sel;
          dec_en_c  = !(ZERO_PROTECT && (sel == SEL_W'(0)));
        end
      end
      ST_SWEEP: begin
        if (idx != LAST) begin
          dec_sel_c = idx_nxt_c;
          dec_en_c  = 1'b1;
        end
      end
      default: begin
        dec_en_c = 1'b0;
      end
    endcase
  end

  wren_sweep_decoder_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (dec_sel_c),
    .en  (dec_en_c),
    .dec (dec_c)
  );

  // FSM, sweep counter and output registers; requests during a sweep are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      out        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      out <= dec_c;
      case (state)
        ST_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= ST_SWEEP;
            idx        <= FIRST;
            busy       <= 1'b1;
            clear_done <= (FIRST == LAST);
          end
        end
        ST_SWEEP: begin
          if (idx != LAST) begin
            idx        <= idx_nxt_c;
            clear_done <= (idx_nxt_c == LAST);
          end else begin
            state      <= ST_IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          idx        <= '0;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wren_sweep_decoder.sv
// Directed bench for wren_sweep_decoder: default, no-zero-protect and 2-bit instances.
module tb_wren_sweep_decoder;

  logic        clock;
  logic        reset;

  logic [4:0]  sel_a;
  logic        en_a, clr_a;
  logic [31:0] out_a;
  logic        busy_a, done_a;

  logic [4:0]  sel_b;
  logic        en_b, clr_b;
  logic [31:0] out_b;
  logic        busy_b, done_b;

  logic [1:0]  sel_c;
  logic        en_c, clr_c;
  logic [3:0]  out_c;
  logic        busy_c, done_c;

  int checks;
  int failures;

  wren_sweep_decoder #(.SEL_W(5), .ZERO_PROTECT(1'b1)) dut_a (
    .clock(clock), .reset(reset), .sel(sel_a), .en(en_a), .clear_req(clr_a),
    .out(out_a), .busy(busy_a), .clear_done(done_a)
  );

  wren_sweep_decoder #(.SEL_W(5), .ZERO_PROTECT(1'b0)) dut_b (
    .clock(clock), .reset(reset), .sel(sel_b), .en(en_b), .clear_req(clr_b),
    .out(out_b), .busy(busy_b), .clear_done(done_b)
  );

  wren_sweep_decoder #(.SEL_W(2), .ZERO_PROTECT(1'b0)) dut_c (
    .clock(clock), .reset(reset), .sel(sel_c), .en(en_c), .clear_req(clr_c),
    .out(out_c), .busy(busy_c), .clear_done(done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then confirm every instance is zero-or-one-hot.
  task automatic tick();
    @(posedge clock);
    #1;
    chk("onehot_a", 32'($onehot0(out_a)), 32'd1);
    chk("onehot_b", 32'($onehot0(out_b)), 32'd1);
    chk("onehot_c", 32'($onehot0(out_c)), 32'd1);
  endtask

  task automatic chk_a(input string tag, input logic [31:0] e_out, input logic e_busy,
                       input logic e_done);
    chk({tag, "_out"},  out_a, e_out);
    chk({tag, "_busy"}, 32'(busy_a), 32'(e_busy));
    chk({tag, "_done"}, 32'(done_a), 32'(e_done));
  endtask

  initial begin
    logic [31:0] exp_v;
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    sel_a = '0; en_a = 1'b0; clr_a = 1'b0;
    sel_b = '0; en_b = 1'b0; clr_b = 1'b0;
    sel_c = '0; en_c = 1'b0; clr_c = 1'b0;

    tick();
    tick();
    chk_a("reset", 32'h0, 1'b0, 1'b0);
    chk("reset_b_out", out_b, 32'h0);
    chk("reset_c_out", 32'(out_c), 32'h0);
    reset = 1'b0;

    // Normal decode, 1-cycle latency
    en_a = 1'b1; sel_a = 5'd7;
    tick();
    chk_a("dec7", 32'h0000_0080, 1'b0, 1'b0);
    en_a = 1'b0;
    tick();
    chk_a("idle", 32'h0, 1'b0, 1'b0);

    // Register 0: masked only when zero-protected
    en_a = 1'b1; sel_a = 5'd0;
    en_b = 1'b1; sel_b = 5'd0;
    tick();
    chk_a("zp_sel0", 32'h0, 1'b0, 1'b0);
    chk("nzp_sel0", out_b, 32'h1);
    sel_b = 5'd31;
    en_a  = 1'b0;
    tick();
    chk("nzp_sel31", out_b, 32'h8000_0000);
    en_b = 1'b0;

    // Full sweep with mid-sweep noise on en/clear_req
    clr_a = 1'b1;
    tick();
    chk_a("sweep_1", 32'h2, 1'b1, 1'b0);
    clr_a = 1'b0;
    for (int k = 2; k < 32; k++) begin
      if (k == 10) begin
        en_a = 1'b1; sel_a = 5'd3; clr_a = 1'b1;
      end else begin
        en_a = 1'b0; clr_a = 1'b0;
      end
      tick();
      exp_v = 32'h1 << k;
      chk_a($sformatf("sweep_%0d", k), exp_v, 1'b1, (k == 31));
    end
    en_a = 1'b0; clr_a = 1'b0;
    tick();
    chk_a("sweep_end", 32'h0, 1'b0, 1'b0);

    // Decode resumes right after the sweep
    en_a = 1'b1; sel_a = 5'd9;
    tick();
    chk_a("post_sweep", 32'h0000_0200, 1'b0, 1'b0);

    // clear_req beats a same-cycle write
    en_a = 1'b1; sel_a = 5'd3; clr_a = 1'b1;
    tick();
    chk_a("clr_wins", 32'h2, 1'b1, 1'b0);
    en_a = 1'b0; clr_a = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      exp_v = 32'h1 << k;
      chk_a($sformatf("sweep2_%0d", k), exp_v, 1'b1, 1'b0);
    end

    // Reset mid-sweep at out=0x400
    reset = 1'b1;
    tick();
    chk_a("mid_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_a("after_reset", 32'h0, 1'b0, 1'b0);
    en_a = 1'b1; sel_a = 5'd5;
    tick();
    chk_a("after_reset_dec5", 32'h0000_0020, 1'b0, 1'b0);
    en_a = 1'b0;

    // 2-bit, unprotected: sweep covers all four outputs
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    chk("c_sweep0_out", 32'(out_c), 32'h1);
    chk("c_sweep0_busy", 32'(busy_c), 32'd1);
    chk("c_sweep0_done", 32'(done_c), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      exp_v = 32'h1 << k;
      chk($sformatf("c_sweep%0d_out", k), 32'(out_c), exp_v);
      chk($sformatf("c_sweep%0d_busy", k), 32'(busy_c), 32'd1);
      chk($sformatf("c_sweep%0d_done", k), 32'(done_c), 32'(k == 3));
    end
    tick();
    chk("c_end_out", 32'(out_c), 32'h0);
    chk("c_end_busy", 32'(busy_c), 32'd0);
    chk("c_end_done", 32'(done_c), 32'd0);
    en_c = 1'b1; sel_c = 2'd2;
    tick();
    chk("c_dec2", 32'(out_c), 32'h4);
    en_c = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
